gtx_mmcm_reset_ctrl: RTL and testbench

Reset/lock sequencer for the GTX user-clock MMCM wrapper. It pulses mmcm_reset, waits for a synchronized and debounced mmcm_lock, and retries on timeout up to a limit. It then releases a downstream user reset. It runs on a free-running reference clock, independent of the MMCM outputs, and sits between the board reset logic and the GTX clock module.

---
 rtl/gtx_mmcm_reset_ctrl_pkg.sv | 27 ++
 rtl/gtx_mmcm_reset_ctrl_if.sv | 23 ++
 rtl/gtx_mmcm_reset_ctrl_sync.sv | 26 ++
 rtl/gtx_mmcm_reset_ctrl.sv | 143 ++++++++++++++
 tb/tb_gtx_mmcm_reset_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gtx_mmcm_reset_ctrl_pkg.sv
// Shared types and default timing for the GTX user-clock MMCM reset/lock sequencer.
// Also provides a constant clog2 used to validate the shared counter width.
package gtx_clk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_HOLD  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } gtx_rst_state_e;

    localparam int DEF_RST_HOLD_CYCLES     = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 7;
    localparam int DEF_CNT_W               = 17;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/gtx_mmcm_reset_ctrl_if.sv
// Control/status bundle between the MMCM reset sequencer and its environment.
// master = the sequencer, slave = board logic / MMCM / monitor side.
interface gtx_mmcm_reset_ctrl_if;
    logic       enable;
    logic       mmcm_lock;
    logic       mmcm_reset;
    logic       user_reset;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;
    logic       lock_lost;
    logic [2:0] state_o;

    modport master (
        input  enable, mmcm_lock,
        output mmcm_reset, user_reset, locked, fail, retry_cnt, lock_lost, state_o
    );

    modport slave (
        output enable, mmcm_lock,
        input  mmcm_reset, user_reset, locked, fail, retry_cnt, lock_lost, state_o
    );
endinterface

// File: rtl/gtx_mmcm_reset_ctrl_sync.sv
// Two-flop synchronizer with a configurable asynchronous-reset value.
// Used for MMCM LOCKED and intended for other slow GTX status inputs.
module gtx_sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/gtx_mmcm_reset_ctrl.sv
// MMCM reset/lock sequencer: pulses MMCM reset, debounces synchronized LOCKED,
// retries on timeout up to a limit, and gates the downstream user reset.
module gtx_mmcm_reset_ctrl
    import gtx_clk_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    gtx_mmcm_reset_ctrl_if.master bus
);
    localparam int CNT_MAX  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES)
                            ? ((RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES)
                            : ((LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES);
    localparam int NEED_W   = clog2(CNT_MAX + 1);

    if (CNT_W < NEED_W) begin : g_cnt_w_check
        $error("CNT_W too small for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    gtx_rst_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             mmcm_reset_q, mmcm_reset_d;
    logic             user_reset_q, user_reset_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             lock_lost;
    logic             lock_s;

    gtx_sync_2ff #(.W(1), .RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.mmcm_lock),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retry_d   = retry_q;
        lock_lost = 1'b0;

        // Dropping enable wins over every other transition, including lock loss.
        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                ST_RST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (int'(retry_q) < MAX_RETRIES) begin
                            state_d = ST_RST_HOLD;
                            retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_STABLE: begin
                    // A glitch restarts the wait without spending a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        lock_lost = 1'b1;
                        state_d   = ST_RST_HOLD;
                        retry_d   = '0;
                    end
                end
                ST_FAIL: cnt_d = '0;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so they change with it, glitch-free.
        mmcm_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST_HOLD) || (state_d == ST_FAIL);
        user_reset_d = (state_d != ST_RUN);
        locked_d     = (state_d == ST_RUN);
        fail_d       = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            mmcm_reset_q <= 1'b1;
            user_reset_q <= 1'b1;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            mmcm_reset_q <= mmcm_reset_d;
            user_reset_q <= user_reset_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
        end
    end

    assign bus.mmcm_reset = mmcm_reset_q;
    assign bus.user_reset = user_reset_q;
    assign bus.locked     = locked_q;
    assign bus.fail       = fail_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.lock_lost  = lock_lost;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_gtx_mmcm_reset_ctrl.sv
// Directed bench for gtx_mmcm_reset_ctrl with hold/timeout/stable/retries = 4/64/8/2.
module tb_gtx_mmcm_reset_ctrl;
    localparam int RH = 4;
    localparam int TO = 64;
    localparam int ST = 8;
    localparam int MR = 2;
    // Lock set just after edge E0: sampled E1, lock_s E2, STABLE entered E3,
    // 8 stable cycles, RUN registered at E11.
    localparam int LOCK_LAT = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gtx_mmcm_reset_ctrl_if bus();

    gtx_mmcm_reset_ctrl #(
        .RST_HOLD_CYCLES     (RH),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR),
        .CNT_W               (17)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input string tag, input int st, input int max);
        int i;
        i = 0;
        while (int'(bus.state_o) != st && i < max) begin
            tick();
            i++;
        end
        chk(tag, 32'(bus.state_o), 32'(st));
    endtask

    // From IDLE with enable=1 and lock low: full sequence up to RUN.
    task automatic lock_seq(input string tag);
        int n;
        wait_st({tag, "_hold_entry"}, 1, 20);
        n = 0;
        while (bus.state_o == 3'd1 && n < 50) begin
            chk({tag, "_hold_mrst"}, 32'(bus.mmcm_reset), 32'd1);
            n++;
            tick();
        end
        chk({tag, "_hold_len"}, 32'(n), 32'(RH));
        chk({tag, "_wait_mrst"}, 32'(bus.mmcm_reset), 32'd0);
        repeat (10) tick();
        chk({tag, "_still_wait"}, 32'(bus.state_o), 32'd2);
        chk({tag, "_urst_pre"}, 32'(bus.user_reset), 32'd1);
        bus.mmcm_lock = 1'b1;
        n = 0;
        while (!bus.locked && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lock_lat"}, 32'(n), 32'(LOCK_LAT));
        chk({tag, "_urst_run"}, 32'(bus.user_reset), 32'd0);
        chk({tag, "_run_st"}, 32'(bus.state_o), 32'd4);
        chk({tag, "_retry"}, 32'(bus.retry_cnt), 32'd0);
    endtask

    initial begin
        int n, i, prev, entries, gaps, run;
        bus.enable    = 1'b0;
        bus.mmcm_lock = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();
        chk("rst_mrst",  32'(bus.mmcm_reset), 32'd1);
        chk("rst_urst",  32'(bus.user_reset), 32'd1);
        chk("rst_lock",  32'(bus.locked),     32'd0);
        chk("rst_fail",  32'(bus.fail),       32'd0);
        chk("rst_retry", 32'(bus.retry_cnt),  32'd0);
        chk("rst_ll",    32'(bus.lock_lost),  32'd0);
        chk("rst_state", 32'(bus.state_o),    32'd0);
        reset = 1'b0;
        tick();

        // Basic lock sequence
        bus.enable = 1'b1;
        lock_seq("t1");

        // Lock drop in RUN
        tick();
        bus.mmcm_lock = 1'b0;
        tick();
        chk("t4_ll_early", 32'(bus.lock_lost), 32'd0);
        tick();
        chk("t4_ll", 32'(bus.lock_lost), 32'd1);
        chk("t4_locked_still", 32'(bus.locked), 32'd1);
        tick();
        chk("t4_ll_end", 32'(bus.lock_lost), 32'd0);
        chk("t4_urst", 32'(bus.user_reset), 32'd1);
        chk("t4_locked", 32'(bus.locked), 32'd0);
        chk("t4_state", 32'(bus.state_o), 32'd1);
        chk("t4_retry", 32'(bus.retry_cnt), 32'd0);
        bus.enable = 1'b0;
        tick();
        chk("t4_idle", 32'(bus.state_o), 32'd0);

        // Lock never arrives: 3 attempts then FAIL
        bus.enable = 1'b1;
        prev = 0; entries = 0; gaps = 0; run = 0; i = 0;
        while (!bus.fail && i < 2000) begin
            tick();
            i++;
            if (bus.state_o == 3'd1 && prev != 1) entries++;
            prev = int'(bus.state_o);
            if (!bus.mmcm_reset) run++;
            else if (run > 0) begin
                chk("t2_gap", 32'(run), 32'(TO));
                gaps++;
                run = 0;
            end
        end
        chk("t2_entries", 32'(entries), 32'(MR + 1));
        chk("t2_gaps", 32'(gaps), 32'(MR + 1));
        chk("t2_fail", 32'(bus.fail), 32'd1);
        chk("t2_mrst", 32'(bus.mmcm_reset), 32'd1);
        chk("t2_retry", 32'(bus.retry_cnt), 32'(MR));
        chk("t2_state", 32'(bus.state_o), 32'd5);
        repeat (5) tick();
        chk("t2_stay", 32'(bus.state_o), 32'd5);
        bus.enable = 1'b0;
        tick();
        chk("t2_fail_clr", 32'(bus.fail), 32'd0);
        chk("t2_idle", 32'(bus.state_o), 32'd0);
        chk("t2_retry_hold", 32'(bus.retry_cnt), 32'(MR));

        // Glitch during STABLE, on the second attempt
        bus.enable = 1'b1;
        i = 0;
        while (!(bus.retry_cnt == 4'd1 && bus.state_o == 3'd2) && i < 500) begin
            tick();
            i++;
        end
        chk("t3_retry1", 32'(bus.retry_cnt), 32'd1);
        bus.mmcm_lock = 1'b1;
        wait_st("t3_stable", 3, 10);
        tick();
        tick();
        bus.mmcm_lock = 1'b0;
        tick();
        bus.mmcm_lock = 1'b1;
        tick();
        tick();
        chk("t3_rewait", 32'(bus.state_o), 32'd2);
        chk("t3_retry_keep", 32'(bus.retry_cnt), 32'd1);
        n = 2;
        while (!bus.locked && n < 100) begin
            tick();
            n++;
        end
        chk("t3_lock_lat", 32'(n), 32'(LOCK_LAT));
        chk("t3_retry_run", 32'(bus.retry_cnt), 32'd1);

        // Enable drop coincides with lock loss in RUN
        tick();
        bus.mmcm_lock = 1'b0;
        tick();
        tick();
        chk("t6_ll_pre", 32'(bus.lock_lost), 32'd1);
        bus.enable = 1'b0;
        #1;
        chk("t6_no_ll", 32'(bus.lock_lost), 32'd0);
        tick();
        chk("t6_idle", 32'(bus.state_o), 32'd0);
        chk("t6_mrst", 32'(bus.mmcm_reset), 32'd1);
        chk("t6_urst", 32'(bus.user_reset), 32'd1);
        chk("t6_ll_after", 32'(bus.lock_lost), 32'd0);

        // Async reset during WAIT_LOCK, then a full restart
        bus.enable = 1'b1;
        wait_st("t5_wait", 2, 50);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_mrst", 32'(bus.mmcm_reset), 32'd1);
        chk("t5_urst", 32'(bus.user_reset), 32'd1);
        chk("t5_state", 32'(bus.state_o), 32'd0);
        tick();
        reset = 1'b0;
        lock_seq("t5");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
